// File: rtl/startup_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// startup_sequencer_pkg : state encoding, default parameters, width helper.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package startup_sequencer_pkg;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    QUALIFY = 2'd1,
    STAGING = 2'd2,
    RUN     = 2'd3
  } state_t;

  localparam int c_DEF_CCLK_STABLE_CYCLES = 512;
  localparam int c_DEF_NUM_STAGES         = 3;
  localparam int c_DEF_STAGE_GAP          = 16;
  localparam int c_DEF_CNT_W              = 64;
  localparam int c_DEF_TIMEOUT_CYCLES     = 1000000;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cclk_sync.sv
// ----------------------------------------------------------------------------
// cclk_sync : two-flop synchroniser for an asynchronous board pin.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cclk_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], d};
    end
  end

  assign q = r_sync[1];

endmodule

`default_nettype wire

// File: rtl/startup_sequencer.sv
// ----------------------------------------------------------------------------
// startup_sequencer : qualifies cclk, releases staged resets, then counts cycles.
// Optional macro STARTUP_WATCHDOG_EN adds a sticky startup timeout. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module startup_sequencer
  import startup_sequencer_pkg::*;
#(
  parameter int CCLK_STABLE_CYCLES = c_DEF_CCLK_STABLE_CYCLES,
  parameter int NUM_STAGES         = c_DEF_NUM_STAGES,
  parameter int STAGE_GAP          = c_DEF_STAGE_GAP,
  parameter int CNT_W              = c_DEF_CNT_W,
  parameter int TIMEOUT_CYCLES     = c_DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cclk,
  output logic                  ready,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic [CNT_W-1:0]      cycle,
  output logic                  cclk_lost,
  output logic                  timeout
);

  localparam int c_QW = cnt_width(CCLK_STABLE_CYCLES);
  localparam int c_GW = cnt_width(STAGE_GAP);

  localparam logic [c_QW-1:0]       c_QUAL_ONE  = c_QW'(1);
  localparam logic [c_QW-1:0]       c_QUAL_LAST = c_QW'(CCLK_STABLE_CYCLES - 1);
  localparam logic [c_GW-1:0]       c_GAP_ONE   = c_GW'(1);
  localparam logic [c_GW-1:0]       c_GAP_LAST  = c_GW'(STAGE_GAP - 1);
  localparam logic [NUM_STAGES-1:0] c_STAGE0    = NUM_STAGES'(1);
  localparam logic [CNT_W-1:0]      c_CYC_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]      c_CYC_MAX   = '1;

  if (CCLK_STABLE_CYCLES < 2 || NUM_STAGES < 1 || STAGE_GAP < 1 ||
      CNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("startup_sequencer: illegal parameter value");
  end

  logic                  w_cclk_s;
  logic [NUM_STAGES-1:0] w_stage_next;
  state_t                r_state;
  logic [c_QW-1:0]       r_qual_cnt;
  logic [c_GW-1:0]       r_gap_cnt;
  logic                  r_ready;
  logic [NUM_STAGES-1:0] r_stage_rst_n;
  logic [CNT_W-1:0]      r_cycle;
  logic                  r_cclk_lost;

  cclk_sync u_cclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cclk),
    .q     (w_cclk_s)
  );

  // Releasing stages by shifting in ones keeps the order strictly monotonic.
  assign w_stage_next = (r_stage_rst_n << 1) | c_STAGE0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= WAIT;
      r_qual_cnt    <= '0;
      r_gap_cnt     <= '0;
      r_ready       <= 1'b0;
      r_stage_rst_n <= '0;
      r_cycle       <= '0;
      r_cclk_lost   <= 1'b0;
    end else begin
      r_cclk_lost <= 1'b0;
      case (r_state)
        WAIT: begin
          if (w_cclk_s) begin
            r_state    <= QUALIFY;
            r_qual_cnt <= c_QUAL_ONE;
          end else begin
            r_qual_cnt <= '0;
          end
        end
        QUALIFY: begin
          if (!w_cclk_s) begin
            r_state    <= WAIT;
            r_qual_cnt <= '0;
          end else if (r_qual_cnt == c_QUAL_LAST) begin
            r_ready       <= 1'b1;
            r_stage_rst_n <= c_STAGE0;
            r_gap_cnt     <= '0;
            r_qual_cnt    <= '0;
            r_cycle       <= '0;
            r_state       <= (NUM_STAGES == 1) ? RUN : STAGING;
          end else begin
            r_qual_cnt <= r_qual_cnt + c_QUAL_ONE;
          end
        end
        STAGING: begin
          if (!w_cclk_s) begin
            r_state       <= WAIT;
            r_ready       <= 1'b0;
            r_stage_rst_n <= '0;
            r_cycle       <= '0;
            r_gap_cnt     <= '0;
            r_cclk_lost   <= 1'b1;
          end else if (r_gap_cnt == c_GAP_LAST) begin
            r_gap_cnt     <= '0;
            r_stage_rst_n <= w_stage_next;
            if (w_stage_next[NUM_STAGES-1]) begin
              r_state <= RUN;
              r_cycle <= '0;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + c_GAP_ONE;
          end
        end
        RUN: begin
          if (!w_cclk_s) begin
            r_state       <= WAIT;
            r_ready       <= 1'b0;
            r_stage_rst_n <= '0;
            r_cycle       <= '0;
            r_gap_cnt     <= '0;
            r_cclk_lost   <= 1'b1;
          end else if (r_cycle != c_CYC_MAX) begin
            r_cycle <= r_cycle + c_CYC_ONE;
          end
        end
        default: r_state <= WAIT;
      endcase
    end
  end

  assign ready       = r_ready;
  assign stage_rst_n = r_stage_rst_n;
  assign cycle       = r_cycle;
  assign cclk_lost   = r_cclk_lost;

`ifdef STARTUP_WATCHDOG_EN
  localparam int              c_WW      = cnt_width(TIMEOUT_CYCLES);
  localparam logic [c_WW-1:0] c_WD_ONE  = c_WW'(1);
  localparam logic [c_WW-1:0] c_WD_LAST = c_WW'(TIMEOUT_CYCLES - 1);

  logic            w_in_startup;
  logic            w_qual_done;
  logic [c_WW-1:0] r_wd_cnt;
  logic            r_timeout;

  assign w_in_startup = (r_state == WAIT) || (r_state == QUALIFY);
  assign w_qual_done  = (r_state == QUALIFY) && w_cclk_s && (r_qual_cnt == c_QUAL_LAST);

  // Counting stops once the flag is set, so the counter can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (!w_in_startup || w_qual_done) begin
      r_wd_cnt <= '0;
    end else if (!r_timeout) begin
      r_wd_cnt <= r_wd_cnt + c_WD_ONE;
      if (r_wd_cnt == c_WD_LAST) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_startup_sequencer.sv
// ----------------------------------------------------------------------------
// tb_startup_sequencer : directed self-checking bench for startup_sequencer.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_startup_sequencer;

`ifdef STARTUP_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cclk = 1'b0;
  logic       ready, lost, timeout;
  logic [2:0] stage;
  logic [7:0] cycle;
  logic       ready_s, lost_s, timeout_s;
  logic [2:0] stage_s;
  logic [3:0] cycle_s;

  int checks = 0;
  int errors = 0;

  logic       exp_ready, exp_lost, exp_to;
  logic [2:0] exp_stage;
  logic [7:0] exp_cycle;
  logic [3:0] exp_cycle_s;

  always #5 clk = ~clk;

  startup_sequencer #(
    .CCLK_STABLE_CYCLES (4),
    .NUM_STAGES         (3),
    .STAGE_GAP          (3),
    .CNT_W              (8),
    .TIMEOUT_CYCLES     (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cclk        (cclk),
    .ready       (ready),
    .stage_rst_n (stage),
    .cycle       (cycle),
    .cclk_lost   (lost),
    .timeout     (timeout)
  );

  startup_sequencer #(
    .CCLK_STABLE_CYCLES (4),
    .NUM_STAGES         (3),
    .STAGE_GAP          (3),
    .CNT_W              (4),
    .TIMEOUT_CYCLES     (20)
  ) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .cclk        (cclk),
    .ready       (ready_s),
    .stage_rst_n (stage_s),
    .cycle       (cycle_s),
    .cclk_lost   (lost_s),
    .timeout     (timeout_s)
  );

  // Leaves rst_n released at a negedge; the next posedge is edge 0.
  task automatic apply_reset(input logic pin);
    @(negedge clk);
    rst_n = 1'b0;
    cclk  = pin;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cclk  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
      checks++;
      if (stage !== 3'b000) begin errors++; $display("FAIL reset_stage: got %b expected 000", stage); end
      checks++;
      if (cycle !== 8'd0) begin errors++; $display("FAIL reset_cycle: got %0d expected 0", cycle); end
      checks++;
      if (lost !== 1'b0) begin errors++; $display("FAIL reset_lost: got %b expected 0", lost); end
      checks++;
      if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    end
  endtask

  task automatic test_startup();
    rst_n = 1'b1;
    for (int e = 0; e <= 21; e++) begin
      @(negedge clk);
      exp_ready   = (e >= 5);
      exp_stage   = (e >= 11) ? 3'b111 : (e >= 8) ? 3'b011 : (e >= 5) ? 3'b001 : 3'b000;
      exp_cycle   = (e >= 11) ? 8'(e - 11) : 8'd0;
      exp_cycle_s = (e >= 11) ? 4'(e - 11) : 4'd0;
      checks++;
      if (ready !== exp_ready) begin errors++; $display("FAIL startup_ready edge %0d: got %b expected %b", e, ready, exp_ready); end
      checks++;
      if (stage !== exp_stage) begin errors++; $display("FAIL startup_stage edge %0d: got %b expected %b", e, stage, exp_stage); end
      checks++;
      if (cycle !== exp_cycle) begin errors++; $display("FAIL startup_cycle edge %0d: got %0d expected %0d", e, cycle, exp_cycle); end
      checks++;
      if (cycle_s !== exp_cycle_s) begin errors++; $display("FAIL startup_cycle4 edge %0d: got %0d expected %0d", e, cycle_s, exp_cycle_s); end
      checks++;
      if (lost !== 1'b0) begin errors++; $display("FAIL startup_lost edge %0d: got %b expected 0", e, lost); end
    end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      exp_cycle_s = (10 + i >= 15) ? 4'd15 : 4'(10 + i);
      checks++;
      if (cycle_s !== exp_cycle_s) begin errors++; $display("FAIL sat_cycle4 step %0d: got %0d expected %0d", i, cycle_s, exp_cycle_s); end
    end
    checks++;
    if (cycle !== 8'd40) begin errors++; $display("FAIL sat_cycle8: got %0d expected 40", cycle); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b expected 0", ready); end
    checks++;
    if (stage !== 3'b000) begin errors++; $display("FAIL midreset_stage: got %b expected 000", stage); end
    checks++;
    if (cycle !== 8'd0) begin errors++; $display("FAIL midreset_cycle: got %0d expected 0", cycle); end
  endtask

  task automatic test_glitch();
    apply_reset(1'b1);
    for (int e = 0; e <= 8; e++) begin
      @(negedge clk);
      exp_ready = (e == 8);
      exp_stage = (e == 8) ? 3'b001 : 3'b000;
      checks++;
      if (ready !== exp_ready) begin errors++; $display("FAIL glitch_ready edge %0d: got %b expected %b", e, ready, exp_ready); end
      checks++;
      if (stage !== exp_stage) begin errors++; $display("FAIL glitch_stage edge %0d: got %b expected %b", e, stage, exp_stage); end
      if (e == 1) cclk = 1'b0;
      if (e == 2) cclk = 1'b1;
    end
  endtask

  task automatic test_loss();
    apply_reset(1'b1);
    repeat (32) @(negedge clk);
    checks++;
    if (cycle !== 8'd20) begin errors++; $display("FAIL loss_precycle: got %0d expected 20", cycle); end
    cclk = 1'b0;
    for (int e = 32; e <= 36; e++) begin
      @(negedge clk);
      exp_lost  = (e == 34);
      exp_ready = (e < 34);
      exp_stage = (e < 34) ? 3'b111 : 3'b000;
      exp_cycle = (e < 34) ? 8'(e - 11) : 8'd0;
      checks++;
      if (lost !== exp_lost) begin errors++; $display("FAIL loss_pulse edge %0d: got %b expected %b", e, lost, exp_lost); end
      checks++;
      if (ready !== exp_ready) begin errors++; $display("FAIL loss_ready edge %0d: got %b expected %b", e, ready, exp_ready); end
      checks++;
      if (stage !== exp_stage) begin errors++; $display("FAIL loss_stage edge %0d: got %b expected %b", e, stage, exp_stage); end
      checks++;
      if (cycle !== exp_cycle) begin errors++; $display("FAIL loss_cycle edge %0d: got %0d expected %0d", e, cycle, exp_cycle); end
    end
    cclk = 1'b1;
    for (int e = 37; e <= 42; e++) begin
      @(negedge clk);
      exp_ready = (e == 42);
      exp_stage = (e == 42) ? 3'b001 : 3'b000;
      checks++;
      if (ready !== exp_ready) begin errors++; $display("FAIL requal_ready edge %0d: got %b expected %b", e, ready, exp_ready); end
      checks++;
      if (stage !== exp_stage) begin errors++; $display("FAIL requal_stage edge %0d: got %b expected %b", e, stage, exp_stage); end
      checks++;
      if (lost !== 1'b0) begin errors++; $display("FAIL requal_lost edge %0d: got %b expected 0", e, lost); end
    end
  endtask

  task automatic test_watchdog();
    apply_reset(1'b0);
    for (int e = 1; e <= 25; e++) begin
      @(negedge clk);
      exp_to = WD_EN && (e >= 20);
      checks++;
      if (timeout !== exp_to) begin errors++; $display("FAIL wd_timeout edge %0d: got %b expected %b", e, timeout, exp_to); end
    end
    cclk = 1'b1;
    for (int e = 26; e <= 31; e++) begin
      @(negedge clk);
      exp_ready = (e == 31);
      checks++;
      if (ready !== exp_ready) begin errors++; $display("FAIL wd_ready edge %0d: got %b expected %b", e, ready, exp_ready); end
      checks++;
      if (timeout !== WD_EN) begin errors++; $display("FAIL wd_sticky edge %0d: got %b expected %b", e, timeout, WD_EN); end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_saturation();
    test_mid_reset();
    test_glitch();
    test_loss();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit expired");
  end

endmodule

`default_nettype wire

// File: doc/startup_sequencer.md
Name: startup_sequencer

Overview:
Parametrised successor to the board's single-bit cclk detection and reset handling. Synchronises the AVR cclk pin, qualifies it as stable, then releases a configurable number of staged active-low reset domains in order. After the last domain is released it runs a free-running cycle counter. Sits at the top of mojo_top, between the board pins (clk, rst_n, cclk) and all downstream logic, including the AVR serial path.

Parameters:
CCLK_STABLE_CYCLES, 512, consecutive synchronised high samples of cclk required before ready; must be >= 2
NUM_STAGES, 3, number of staged reset outputs; must be >= 1
STAGE_GAP, 16, clock cycles between release of successive stages; must be >= 1
CNT_W, 64, width of the run-time cycle counter
TIMEOUT_CYCLES, 1000000, watchdog limit; used only with STARTUP_WATCHDOG_EN

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cclk  in  1  raw AVR configuration clock/ready pin, asynchronous to clk
ready  out  1  cclk qualified stable
stage_rst_n  out  NUM_STAGES  per-domain active-low resets; bit 0 is released first
cycle  out  CNT_W  cycles elapsed in RUN, saturating
cclk_lost  out  1  one-cycle pulse when cclk drops after qualification
timeout  out  1  sticky watchdog flag; tied 0 without the macro

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous, active-low.
  - rst_n low immediately forces all outputs to 0, the state to WAIT, and all counters and synchroniser flops to 0.
  - Reset mid-operation behaves identically.
- Synchroniser: 2 flops, giving cclk_s.
  - Edge 0 is the first edge on which the pin is captured high.
  - cclk_s is 1 from edge 1.
- FSM states: WAIT, QUALIFY, STAGING, RUN. All outputs are registered.
- WAIT: if cclk_s = 1, go to QUALIFY with qual_cnt = 1; otherwise qual_cnt = 0.
- QUALIFY:
  - cclk_s = 0: go to WAIT, qual_cnt = 0.
  - qual_cnt = N-1 and cclk_s = 1: go to STAGING. On the same edge, ready = 1 and stage_rst_n[0] = 1, gap_cnt = 0.
  - Otherwise qual_cnt increments.
  - Result: ready rises on edge N+1.
- STAGING:
  - gap_cnt counts each cycle; stage k is released on edge (entry + k*STAGE_GAP).
  - On the edge the last stage is released, enter RUN with cycle = 0.
  - If NUM_STAGES = 1, go directly from QUALIFY to RUN on the ready edge.
- RUN:
  - cycle increments by 1 each edge.
  - Saturates at 2^CNT_W - 1, with no wrap.
- Loss (STAGING or RUN sampling cclk_s = 0), all on the same edge:
  - state WAIT
  - ready = 0, stage_rst_n = all 0, cycle = 0
  - cclk_lost = 1 for exactly one cycle
  - Loss takes priority over a simultaneous stage release or RUN entry.
- Stage release order is monotonic. A stage is never released before a lower-indexed stage.
- Counter widths: qual_cnt is $clog2(CCLK_STABLE_CYCLES+1); gap_cnt is $clog2(STAGE_GAP+1).

Optional Feature:
STARTUP_WATCHDOG_EN
- With the macro: a watchdog counter increments every cycle in WAIT or QUALIFY and is cleared on entering STAGING.
  - On reaching TIMEOUT_CYCLES, timeout is set to 1.
  - timeout stays set until rst_n; it is sticky and does not affect the FSM.
- Without the macro: no watchdog counter exists and timeout is constant 0.

Decomposition:
- Package startup_sequencer_pkg:
  - state enum (WAIT/QUALIFY/STAGING/RUN)
  - default parameter constants
  - a clog2-based width helper
- One natural sub-module: cclk_sync, a 2-flop synchroniser with async active-low reset to 0, reusable for other board pins.

Test Plan:
All scenarios use N=4, STAGE_GAP=3, NUM_STAGES=3, CNT_W=8 unless stated.
1. Reset: hold rst_n=0 with cclk=1 -> ready=0, stage_rst_n=000, cycle=0, cclk_lost=0 throughout.
2. Steady cclk high from edge 0:
   - ready=1 and stage_rst_n=001 at edge 5
   - stage_rst_n=011 at edge 8, 111 at edge 11
   - cycle=1 at edge 12, cycle=10 at edge 21
3. Glitch: cclk_s high for 2 samples then low 1 cycle, then high -> ready stays 0 until 4 fresh consecutive high samples.
4. Loss: drop cclk at cycle=20 in RUN -> two edges later cclk_lost=1 for one cycle, ready=0, stage_rst_n=000, cycle=0; requalifies after cclk returns.
5. Saturation: CNT_W=4 with 30 cycles in RUN -> cycle stays 15.
6. Watchdog (macro defined, TIMEOUT_CYCLES=20, cclk=0) -> timeout=1 at cycle 20 and stays 1 after a later cclk qualification; without the macro, timeout=0.
